// File: rtl/spi_loader.sv
// SPI slave that assembles MSB-first 32-bit words and writes them to memory at
// consecutive word addresses starting at BASE_ADDR for every chip-select frame.
module spi_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        cs_n,
   output logic        load_active,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic [15:0] word_count,
   output logic        frame_err
);

   typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

   state_t      state_q, state_d;
   logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic        mosi_s1_q, mosi_s2_q;
   logic        cs_s1_q, cs_s2_q;
   logic [31:0] shreg_q, shreg_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] addr_cnt_q, addr_cnt_d;
   logic [15:0] word_count_q, word_count_d;
   logic        frame_err_q, frame_err_d;
   logic        load_active_q, load_active_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        sclk_rise;

   assign sclk_rise = sclk_s2_q & ~sclk_s3_q;

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      addr_cnt_d   = addr_cnt_q;
      word_count_d = word_count_q;
      frame_err_d  = frame_err_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      case (state_q)
         IDLE: begin
            if (!cs_s2_q) begin
               state_d      = SHIFT;
               bit_cnt_d    = 6'd0;
               addr_cnt_d   = BASE_ADDR;
               word_count_d = 16'd0;
               frame_err_d  = 1'b0;
            end
         end
         SHIFT: begin
            // Chip-select release takes priority over a coincident sclk edge.
            if (cs_s2_q) begin
               state_d   = IDLE;
               bit_cnt_d = 6'd0;
               if (bit_cnt_q != 6'd0) frame_err_d = 1'b1;
            end else if (sclk_rise) begin
               shreg_d   = {shreg_q[30:0], mosi_s2_q};
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd31) begin
                  // Outputs are registered alongside the WRITE state so they line up with it.
                  state_d   = WRITE;
                  wr_en_d   = 1'b1;
                  wr_data_d = {shreg_q[30:0], mosi_s2_q};
                  wr_addr_d = addr_cnt_q;
               end
            end
         end
         WRITE: begin
            addr_cnt_d   = addr_cnt_q + 32'd4;
            word_count_d = word_count_q + 16'd1;
            bit_cnt_d    = 6'd0;
            state_d      = cs_s2_q ? IDLE : SHIFT;
         end
         default: state_d = IDLE;
      endcase
      load_active_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sclk_s1_q     <= 1'b0;
         sclk_s2_q     <= 1'b0;
         sclk_s3_q     <= 1'b0;
         mosi_s1_q     <= 1'b0;
         mosi_s2_q     <= 1'b0;
         cs_s1_q       <= 1'b1;
         cs_s2_q       <= 1'b1;
         shreg_q       <= 32'd0;
         bit_cnt_q     <= 6'd0;
         addr_cnt_q    <= BASE_ADDR;
         word_count_q  <= 16'd0;
         frame_err_q   <= 1'b0;
         load_active_q <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= 32'd0;
         wr_data_q     <= 32'd0;
      end else begin
         state_q       <= state_d;
         sclk_s1_q     <= sclk;
         sclk_s2_q     <= sclk_s1_q;
         sclk_s3_q     <= sclk_s2_q;
         mosi_s1_q     <= mosi;
         mosi_s2_q     <= mosi_s1_q;
         cs_s1_q       <= cs_n;
         cs_s2_q       <= cs_s1_q;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         addr_cnt_q    <= addr_cnt_d;
         word_count_q  <= word_count_d;
         frame_err_q   <= frame_err_d;
         load_active_q <= load_active_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
      end
   end

   assign load_active = load_active_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign word_count  = word_count_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_loader.sv
// Bench for spi_loader: three instances with different base addresses share one
// SPI master; a scoreboard queue holds each expected write and a monitor checks it.
module tb_spi_loader;

   logic clk;
   logic rst_n;
   logic sclk;
   logic mosi;
   logic cs_n;

   logic        la [3];
   logic        we [3];
   logic [31:0] wa [3];
   logic [31:0] wd [3];
   logic [15:0] wc [3];
   logic        fe [3];

   localparam logic [31:0] BASES [3] = '{32'h0000_0000, 32'h0000_0100, 32'hFFFF_FFFC};

   int n_vec;
   int n_err;
   int cyc;
   int frame_words;
   // Entry: {expected wr_en cycle[31:0], word index in frame[15:0], data[31:0]}
   logic [79:0] exp_q[$];

   spi_loader #(.BASE_ADDR(32'h0000_0000)) u0 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .load_active(la[0]), .wr_en(we[0]), .wr_addr(wa[0]), .wr_data(wd[0]),
      .word_count(wc[0]), .frame_err(fe[0]));
   spi_loader #(.BASE_ADDR(32'h0000_0100)) u1 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .load_active(la[1]), .wr_en(we[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
      .word_count(wc[1]), .frame_err(fe[1]));
   spi_loader #(.BASE_ADDR(32'hFFFF_FFFC)) u2 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .load_active(la[2]), .wr_en(we[2]), .wr_addr(wa[2]), .wr_data(wd[2]),
      .word_count(wc[2]), .frame_err(fe[2]));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // A synchronized sclk rise becomes visible two clk edges after the pin changes,
   // is detected in the following cycle, and the write strobe appears one cycle later.
   initial begin : monitor
      logic [79:0] e;
      forever begin
         @(negedge clk);
         if (we[0] | we[1] | we[2]) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_wr: got wr_en=1 expected no write");
            end else begin
               e = exp_q.pop_front();
               check("wr_cycle", 32'(cyc), e[79:48]);
               for (int i = 0; i < 3; i++) begin
                  check("wr_en", {31'd0, we[i]}, 32'd1);
                  check("wr_addr", wa[i], BASES[i] + 32'(e[47:32]) * 32'd4);
                  check("wr_data", wd[i], e[31:0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      frame_words = 0;
      clk_wait(4);
   endtask

   task automatic shift_bits(input logic [31:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         mosi = w[31-i];
         clk_wait($urandom_range(3, 6));
         sclk = 1'b1;
         if (i == 31) exp_q.push_back({32'(cyc + 3), 16'(frame_words), w});
         clk_wait($urandom_range(3, 6));
         sclk = 1'b0;
      end
      if (nbits == 32) frame_words++;
      clk_wait(4);
   endtask

   task automatic end_check(input int exp_words, input logic exp_err);
      clk_wait(6);
      for (int i = 0; i < 3; i++) begin
         check("load_active_end", {31'd0, la[i]}, 32'd0);
         check("word_count", {16'd0, wc[i]}, {16'd0, 16'(exp_words)});
         check("frame_err", {31'd0, fe[i]}, {31'd0, exp_err});
      end
      check("pending_writes", exp_q.size(), 32'd0);
   endtask

   task automatic cs_high_check(input int exp_words, input logic exp_err);
      cs_n = 1'b1;
      end_check(exp_words, exp_err);
   endtask

   task automatic reset_check();
      rst_n = 1'b0;
      clk_wait(2);
      for (int i = 0; i < 3; i++) begin
         check("rst_load_active", {31'd0, la[i]}, 32'd0);
         check("rst_wr_en", {31'd0, we[i]}, 32'd0);
         check("rst_wr_addr", wa[i], 32'd0);
         check("rst_wr_data", wd[i], 32'd0);
         check("rst_word_count", {16'd0, wc[i]}, 32'd0);
         check("rst_frame_err", {31'd0, fe[i]}, 32'd0);
      end
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int nw;
      int abort_bits;
      n_vec = 0;
      n_err = 0;
      frame_words = 0;
      sclk = 1'b0;
      mosi = 1'b0;
      cs_n = 1'b1;
      rst_n = 1'b0;
      clk_wait(3);
      reset_check();
      clk_wait(3);

      // single word
      cs_low();
      shift_bits(32'hDEAD_BEEF, 32);
      cs_high_check(1, 1'b0);

      // three instruction words
      cs_low();
      shift_bits(32'h0000_0013, 32);
      shift_bits(32'h0010_0093, 32);
      shift_bits(32'h0020_8113, 32);
      cs_high_check(3, 1'b0);

      // abort after 17 bits, then a clean frame clears the error
      cs_low();
      shift_bits($urandom, 17);
      cs_high_check(0, 1'b1);
      cs_low();
      shift_bits($urandom, 32);
      cs_high_check(1, 1'b0);

      // cs_n release coincides with the 32nd sclk rise: the edge is dropped
      cs_low();
      shift_bits($urandom, 31);
      sclk = 1'b1;
      cs_n = 1'b1;
      end_check(0, 1'b1);
      sclk = 1'b0;
      clk_wait(4);

      // reset mid-frame with cs_n held low, then a full word in the new frame
      cs_low();
      shift_bits($urandom, 10);
      reset_check();
      frame_words = 0;
      clk_wait(5);
      shift_bits($urandom, 32);
      cs_high_check(1, 1'b0);

      // randomized frames, some ending mid-word
      for (int f = 0; f < 8; f++) begin
         nw = $urandom_range(0, 4);
         abort_bits = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : 0;
         cs_low();
         for (int k = 0; k < nw; k++) shift_bits($urandom, 32);
         if (abort_bits != 0) shift_bits($urandom, abort_bits);
         cs_high_check(nw, abort_bits != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_loader.md
SPI_LOADER -- requirements
Module: spi_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written in each frame.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 sclk  input  1  SPI serial clock from external master, asynchronous to clk.
REQ-005 mosi  input  1  SPI serial data, MSB first, asynchronous.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 load_active  output  1  high while a frame is in progress; drives Sel of the 32-bit memory-address/data 2:1 mux (1 = loader owns memory port).
REQ-008 wr_en  output  1  one-clk write strobe to instruction/data memory.
REQ-009 wr_addr  output  32  byte address of the current write.
REQ-010 wr_data  output  32  assembled word.
REQ-011 word_count  output  16  words written in the current or most recent frame.
REQ-012 frame_err  output  1  sticky flag: last frame ended mid-word.

Function
REQ-013 sclk, mosi and cs_n SHALL each pass through a 2-flop synchronizer; a third flop on synced sclk SHALL provide rising-edge detect (sclk_rise).
REQ-014 FSM states SHALL be IDLE, SHIFT, WRITE.
REQ-015 IDLE: when synced cs_n = 0 -> SHIFT; same cycle clear bit_cnt, load addr_cnt = BASE_ADDR, word_count = 0, frame_err = 0.
REQ-016 SHIFT: on sclk_rise with synced cs_n = 0, shreg <= {shreg[30:0], mosi_sync}, bit_cnt increments (6-bit counter, 0..32).
REQ-017 SHIFT: when the 32nd bit is captured, the next state SHALL be WRITE.
REQ-018 WRITE: exactly one cycle; wr_en = 1, wr_data = shreg, wr_addr = addr_cnt; on exit addr_cnt += 4, word_count += 1, bit_cnt = 0.
REQ-019 WRITE exit: synced cs_n = 0 -> SHIFT; synced cs_n = 1 -> IDLE.
REQ-020 Latency: wr_en SHALL assert in the clk cycle immediately after the cycle in which the 32nd sclk_rise is detected.
REQ-021 SHIFT with synced cs_n = 1 and bit_cnt = 0 -> IDLE, frame_err unchanged (clean end).
REQ-022 SHIFT with synced cs_n = 1 and bit_cnt != 0 -> IDLE, frame_err = 1, partial word discarded, no wr_en.
REQ-023 cs_n deassertion and sclk_rise in the same cycle: cs_n wins, the edge is not shifted.
REQ-024 addr_cnt SHALL wrap modulo 2^32; word_count SHALL wrap modulo 2^16.
REQ-025 load_active SHALL be 1 in SHIFT and WRITE, 0 in IDLE (registered from state, no glitch).
REQ-026 wr_addr and wr_data SHALL hold their last values outside WRITE; wr_en SHALL be 0 outside WRITE.
REQ-027 sclk high and low phases SHALL each be at least 3 clk periods; faster sclk is outside the operating range.
REQ-028 word_count and frame_err SHALL hold after the frame ends until the next frame start.

Reset
REQ-029 rst_n = 0 at a clk edge SHALL force: state IDLE, load_active 0, wr_en 0, wr_addr 0, wr_data 0, word_count 0, frame_err 0, shreg 0, bit_cnt 0, addr_cnt BASE_ADDR; synchronizer flops sclk 0, mosi 0, cs_n 1.
REQ-030 Reset asserted mid-frame SHALL abort without wr_en; after release, a frame is only recognised once synced cs_n is low (a still-low cs_n starts a new frame at BASE_ADDR).

Verification
REQ-031 Single word: cs_n low, shift 32'hDEAD_BEEF, cs_n high -> one wr_en pulse, wr_addr = BASE_ADDR, wr_data = 32'hDEADBEEF, word_count = 1, frame_err = 0, load_active back to 0.
REQ-032 Three words 32'h00000013, 32'h00100093, 32'h00208113 with BASE_ADDR = 32'h100 -> wr_addr 0x100, 0x104, 0x108, word_count = 3.
REQ-033 Abort: cs_n high after 17 bits -> no wr_en, frame_err = 1; next full frame clears frame_err and writes at BASE_ADDR.
REQ-034 Latency: 32nd sclk_rise detected in cycle N -> wr_en high only in cycle N+1, for exactly one cycle.
REQ-035 Reset mid-frame after 10 bits, cs_n held low -> no write; subsequent 32 bits write at BASE_ADDR with word_count = 1.
REQ-036 Wrap: BASE_ADDR = 32'hFFFF_FFFC, two words -> wr_addr 0xFFFFFFFC then 0x00000000.
